// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus transmitter and its future receive side.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StHdrData,
    StCrc,
    StStop,
    StGap
  } bus_state_e;

  // x^4 + x + 1, high-order term implicit
  localparam logic [3:0] CrcPoly = 4'h3;

  function automatic int unsigned frame_len(input int unsigned addr_w,
                                            input int unsigned data_w,
                                            input int unsigned crc_w);
    return 2 + 2 * addr_w + data_w + crc_w;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_tx_rr_arbiter.sv
// Round-robin arbiter: combinational priority search from a registered pointer.
module rr_arbiter #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             update,
  input  logic [IDX_W-1:0] served,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  // First pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr_q)) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    any   = found;
    grant = found ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= (served == IDX_W'(N - 1)) ? '0 : served + IDX_W'(1);
    end
  end

endmodule

// File: rtl/serial_bus_arbiter_tx.sv
// Arbitrated serial transmitter: start, src, dst, data, CRC, stop, then an idle gap.
module serial_bus_arbiter_tx
  import serial_bus_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CRC_W  = 4,
  parameter int unsigned GAP    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   data_in,
  input  logic [N*ADDR_W-1:0]   dest_addr,
  output logic [N-1:0]          grant,
  output logic [N-1:0]          done,
  output logic                  bus_out,
  output logic                  bus_busy,
  output logic [ADDR_W-1:0]     cur_src
);

  localparam int unsigned FrameLen = frame_len(ADDR_W, DATA_W, CRC_W);
  localparam int unsigned HdrW     = FrameLen - CRC_W - 2;
  localparam int unsigned MaxField = (HdrW > CRC_W) ? ((HdrW > GAP) ? HdrW : GAP)
                                                    : ((CRC_W > GAP) ? CRC_W : GAP);
  localparam int unsigned CntW     = $clog2(MaxField + 1);
  localparam logic [CRC_W-1:0] Poly = CRC_W'(CrcPoly);

  bus_state_e        state_q;
  logic [HdrW-1:0]   sh_q;
  logic [CRC_W-1:0]  crc_q, crc_next;
  logic [CntW-1:0]   cnt_q;

  logic [N-1:0]      arb_grant;
  logic [ADDR_W-1:0] arb_idx;
  logic              arb_any;
  logic              launch;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_dst;

  rr_arbiter #(
    .N     (N),
    .IDX_W (ADDR_W)
  ) u_rr_arbiter (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .update    (state_q == StStop),
    .served    (cur_src),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_data = '0;
    sel_dst  = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) begin
        sel_data = data_in[i*DATA_W +: DATA_W];
        sel_dst  = dest_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // The last gap cycle arbitrates directly so back-to-back frames keep an L+GAP period.
  assign launch = arb_any &&
                  ((state_q == StIdle) || (state_q == StGap && cnt_q == CntW'(GAP - 1)));

  assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^
                    ((sh_q[HdrW-1] ^ crc_q[CRC_W-1]) ? Poly : '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      bus_out  <= 1'b1;
      bus_busy <= 1'b0;
      grant    <= '0;
      done     <= '0;
      cur_src  <= '0;
    end else begin
      done <= '0;
      if (launch) begin
        sh_q     <= {arb_idx, sel_dst, sel_data};
        crc_q    <= '0;
        cnt_q    <= '0;
        bus_out  <= 1'b0;
        bus_busy <= 1'b1;
        grant    <= arb_grant;
        cur_src  <= arb_idx;
        state_q  <= StStart;
      end else begin
        case (state_q)
          StStart: begin
            bus_out <= sh_q[HdrW-1];
            crc_q   <= crc_next;
            sh_q    <= sh_q << 1;
            cnt_q   <= '0;
            state_q <= StHdrData;
          end
          StHdrData: begin
            if (cnt_q == CntW'(HdrW - 1)) begin
              bus_out <= crc_q[CRC_W-1];
              crc_q   <= crc_q << 1;
              cnt_q   <= '0;
              state_q <= StCrc;
            end else begin
              bus_out <= sh_q[HdrW-1];
              crc_q   <= crc_next;
              sh_q    <= sh_q << 1;
              cnt_q   <= cnt_q + CntW'(1);
            end
          end
          StCrc: begin
            if (cnt_q == CntW'(CRC_W - 1)) begin
              bus_out <= 1'b1;
              done    <= grant;
              state_q <= StStop;
            end else begin
              bus_out <= crc_q[CRC_W-1];
              crc_q   <= crc_q << 1;
              cnt_q   <= cnt_q + CntW'(1);
            end
          end
          StStop: begin
            grant    <= '0;
            bus_busy <= 1'b0;
            cur_src  <= '0;
            cnt_q    <= '0;
            state_q  <= StGap;
          end
          StGap: begin
            if (cnt_q == CntW'(GAP - 1)) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter_tx.sv
// Directed bench for serial_bus_arbiter_tx at default and reduced parameters.
module tb_serial_bus_arbiter_tx;

  logic           clock;
  logic           reset_n;
  logic [15:0]    req;
  logic [1023:0]  data_in;
  logic [63:0]    dest_addr;
  logic [15:0]    grant, done;
  logic           bus_out, bus_busy;
  logic [3:0]     cur_src;

  logic [3:0]     req_s;
  logic [31:0]    data_s;
  logic [7:0]     dest_s;
  logic [3:0]     grant_s, done_s;
  logic           bus_s, busy_s;
  logic [1:0]     cur_src_s;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] g_seen [4];
  int          st_seen [4];
  int          low_seen [4];

  serial_bus_arbiter_tx u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .data_in   (data_in),
    .dest_addr (dest_addr),
    .grant     (grant),
    .done      (done),
    .bus_out   (bus_out),
    .bus_busy  (bus_busy),
    .cur_src   (cur_src)
  );

  serial_bus_arbiter_tx #(
    .N      (4),
    .ADDR_W (2),
    .DATA_W (8),
    .CRC_W  (4),
    .GAP    (1)
  ) u_small (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req_s),
    .data_in   (data_s),
    .dest_addr (dest_s),
    .grant     (grant_s),
    .done      (done_s),
    .bus_out   (bus_s),
    .bus_busy  (busy_s),
    .cur_src   (cur_src_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] crc_ref(input logic [127:0] msg, input int nbits);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = msg[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Called while the start bit is on the bus; records nb bits MSB-first.
  task automatic capture(input int nb, input int mod_at, output logic [127:0] f,
                         output int done_idx, output int gcnt, output int done_cnt);
    f = '0; done_idx = -1; gcnt = 0; done_cnt = 0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) tick();
      f = {f[126:0], bus_out};
      if (grant != 16'h0) gcnt++;
      if (done != 16'h0) begin
        done_idx = i;
        done_cnt++;
      end
      if (i == mod_at) begin
        req            = 16'h0;
        data_in[63:0]  = ~data_in[63:0];
        dest_addr[3:0] = ~dest_addr[3:0];
      end
    end
  endtask

  task automatic run_frames(input int n);
    int   nf;
    logic prev;
    nf   = 0;
    prev = bus_busy;
    for (int k = 0; k < 4; k++) begin
      g_seen[k] = '0; st_seen[k] = 0; low_seen[k] = 0;
    end
    for (int cyc = 0; cyc < n * 79 + 20 && nf < n; cyc++) begin
      tick();
      if (bus_busy && !prev) begin
        g_seen[nf]  = grant;
        st_seen[nf] = cyc;
        nf++;
      end else if (!bus_busy && nf > 0 && nf < n) begin
        low_seen[nf-1]++;
      end
      prev = bus_busy;
    end
    check("frame_starts_seen", nf, n);
  endtask

  initial begin
    logic [127:0] f;
    logic [77:0]  e;
    logic [17:0]  e6;
    logic [71:0]  m4;
    int           didx, gcnt, dcnt;

    reset_n = 1'b0;
    req = '0; data_in = '0; dest_addr = '0;
    req_s = '0; data_s = '0; dest_s = '0;
    tick();
    check("rst_bus_out", bus_out, 1'b1);
    check("rst_grant", grant, 16'h0);
    check("rst_done", done, 16'h0);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_cur_src", cur_src, 4'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_bus_out", bus_out, 1'b1);

    // Single frame from node 0 to node 1, data 1
    req = 16'h0001; data_in[63:0] = 64'h1; dest_addr[3:0] = 4'h1;
    tick();
    check("t1_grant", grant, 16'h0001);
    check("t1_start_bit", bus_out, 1'b0);
    check("t1_busy", bus_busy, 1'b1);
    check("t1_cur_src", cur_src, 4'h0);
    req = 16'h0;
    capture(78, -1, f, didx, gcnt, dcnt);
    e = {1'b0, 4'h0, 4'h1, 64'h1, 4'b0110, 1'b1};
    check("t1_frame", f, {50'h0, e});
    check("t1_done_pos", didx, 77);
    check("t1_done_cnt", dcnt, 1);
    check("t1_grant_len", gcnt, 78);
    tick();
    check("t1_gap_grant", grant, 16'h0);
    check("t1_gap_busy", bus_busy, 1'b0);
    check("t1_gap_bus", bus_out, 1'b1);

    // Three nodes holding req: 0,1,2,0 at 79-cycle spacing
    do_reset();
    req = 16'h0007;
    run_frames(4);
    check("t2_g0", g_seen[0], 16'h0001);
    check("t2_g1", g_seen[1], 16'h0002);
    check("t2_g2", g_seen[2], 16'h0004);
    check("t2_g3", g_seen[3], 16'h0001);
    check("t2_period01", st_seen[1] - st_seen[0], 79);
    check("t2_period12", st_seen[2] - st_seen[1], 79);
    check("t2_period23", st_seen[3] - st_seen[2], 79);
    check("t2_low0", low_seen[0], 1);
    check("t2_low1", low_seen[1], 1);
    check("t2_low2", low_seen[2], 1);
    req = 16'h0;
    for (int i = 0; i < 90; i++) tick();

    // Wrap-around after serving node 2
    do_reset();
    req = 16'h0004;
    run_frames(1);
    check("t3_first", g_seen[0], 16'h0004);
    req = 16'h8005;
    run_frames(3);
    check("t3_wrap_15", g_seen[0], 16'h8000);
    check("t3_wrap_0", g_seen[1], 16'h0001);
    check("t3_wrap_2", g_seen[2], 16'h0004);
    check("t3_cur_src", cur_src, 4'h2);
    req = 16'h0;
    for (int i = 0; i < 90; i++) tick();

    // Inputs changed mid-frame do not affect the latched frame
    do_reset();
    data_in[63:0] = 64'hDEADBEEF01234567; dest_addr[3:0] = 4'h9; req = 16'h0001;
    tick();
    m4 = {4'h0, 4'h9, 64'hDEADBEEF01234567};
    capture(78, 30, f, didx, gcnt, dcnt);
    e = {1'b0, m4, crc_ref({56'h0, m4}, 72), 1'b1};
    check("t4_frame", f, {50'h0, e});
    check("t4_done_cnt", dcnt, 1);
    tick();
    tick();
    check("t4_no_regrant", grant, 16'h0);
    check("t4_idle_busy", bus_busy, 1'b0);

    // Async reset at bit 30 of a frame from node 1
    req = 16'h0002;
    tick();
    check("t5_grant", grant, 16'h0002);
    req = 16'h0;
    for (int i = 0; i < 30; i++) tick();
    check("t5_midframe_busy", bus_busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_async_bus", bus_out, 1'b1);
    check("t5_async_grant", grant, 16'h0);
    check("t5_async_busy", bus_busy, 1'b0);
    req = 16'h0020;
    tick();
    check("t5_no_done", done, 16'h0);
    reset_n = 1'b1;
    tick();
    check("t5_node5_grant", grant, 16'h0020);
    check("t5_node5_src", cur_src, 4'h5);
    check("t5_node5_start", bus_out, 1'b0);
    req = 16'h0;
    for (int i = 0; i < 90; i++) tick();

    // Reduced parameters: node 3 to dst 2, data A5
    req_s = 4'b1000; data_s[31:24] = 8'hA5; dest_s[7:6] = 2'b10;
    tick();
    check("t6_grant", grant_s, 4'b1000);
    check("t6_cur_src", cur_src_s, 2'd3);
    req_s = 4'b0;
    f = '0; didx = -1; gcnt = 0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) tick();
      f = {f[126:0], bus_s};
      if (grant_s != 4'b0) gcnt++;
      if (done_s != 4'b0) didx = i;
    end
    check("t6_busy_at_stop", busy_s, 1'b1);
    e6 = {1'b0, 2'b11, 2'b10, 8'hA5, 4'b1110, 1'b1};
    check("t6_frame", f, {110'h0, e6});
    check("t6_src_field", f[16:15], 2'b11);
    check("t6_crc_model", f[4:1], crc_ref({116'h0, 2'b11, 2'b10, 8'hA5}, 12));
    check("t6_done_pos", didx, 17);
    check("t6_grant_len", gcnt, 18);
    tick();
    check("t6_len_end_busy", busy_s, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
